// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 codes, FSM encoding and store-merge helper for the load/store unit
package lsu_pkg;

    // RISC-V load width codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // RISC-V store width codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD     = 3'd1;
    localparam logic [2:0] ST_STORE_RD = 3'd2;
    localparam logic [2:0] ST_STORE_WR = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    // Replace the addressed byte or half of old_word with the low bits of
    // wdata; a full-word store passes wdata through unchanged.
    function automatic logic [31:0] merge_store(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [2:0]  f3,
        input logic [1:0]  off
    );
        logic [31:0] w;
        w = old_word;
        case (f3[1:0])
            2'b00: begin
                case (off)
                    2'd0:    w[7:0]   = wdata[7:0];
                    2'd1:    w[15:8]  = wdata[7:0];
                    2'd2:    w[23:16] = wdata[7:0];
                    default: w[31:24] = wdata[7:0];
                endcase
            end
            2'b01: begin
                if (off[1]) w[31:16] = wdata[15:0];
                else        w[15:0]  = wdata[15:0];
            end
            default: w = wdata;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// rtl/lsu_load_extend.sv - byte/half lane select with sign or zero extension for loads
//   word     : full word read from memory
//   byte_off : addr[1:0] of the access
//   funct3   : load width code
//   data     : extended load result
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        case (byte_off)
            2'd0:    sel_byte = word[7:0];
            2'd1:    sel_byte = word[15:8];
            2'd2:    sel_byte = word[23:16];
            default: sel_byte = word[31:24];
        endcase
        sel_half = byte_off[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_LB:   data = {{24{sel_byte[7]}}, sel_byte};
            F3_LH:   data = {{16{sel_half[15]}}, sel_half};
            F3_LBU:  data = {24'd0, sel_byte};
            F3_LHU:  data = {16'd0, sel_half};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle byte/half/word load-store unit over a word-wide memory
//   clk, reset          : clock (rising) and asynchronous active-high reset
//   start, is_store     : request strobe (taken only in IDLE) and direction
//   funct3, addr        : RISC-V width code and byte address
//   store_data          : store source value
//   load_data           : extended load result, held until the next load completes
//   busy, done, err     : not-idle flag, one-cycle completion pulse, fault flag (valid with done)
//   mem_*               : word-aligned memory port, mem_rdata is a combinational read
// Optional feature macro: LSU_MISALIGN_TRAP_EN (fault misaligned half/word accesses
// instead of masking the low address bits).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DMEM_BYTES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_store,
    output logic        mem_load,
    output logic        mem_en,
    input  logic [31:0] mem_rdata
);

    localparam logic [32:0] MEM_LIMIT = 33'(DMEM_BYTES);

    logic [2:0]  state_q,     state_d;
    logic [2:0]  funct3_q,    funct3_d;
    logic [31:0] addr_q,      addr_d;
    logic [31:0] sdata_q,     sdata_d;
    logic [31:0] rdata_q,     rdata_d;
    logic [31:0] load_data_q, load_data_d;
    logic        err_q,       err_d;

    logic        f3_ok;
    logic        misalign;
    logic        range_fault;
    logic        fault;
    logic [31:0] eff_addr;
    logic [32:0] last_byte;
    logic [31:0] ext_data;

    // Request qualification, evaluated on the raw inputs at the start edge.
    always_comb begin
        if (is_store) begin
            f3_ok = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        end else begin
            f3_ok = (funct3 == F3_LB)  || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                    (funct3 == F3_LBU) || (funct3 == F3_LHU);
        end

`ifdef LSU_MISALIGN_TRAP_EN
        misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        eff_addr = addr;
`else
        // Misaligned accesses are forced onto their natural boundary.
        misalign = 1'b0;
        case (funct3[1:0])
            2'b01:   eff_addr = {addr[31:1], 1'b0};
            2'b10:   eff_addr = {addr[31:2], 2'b00};
            default: eff_addr = addr;
        endcase
`endif

        // Last byte of the addressed word, one bit wider so addr near 2^32 cannot wrap.
        last_byte   = {1'b0, addr[31:2], 2'b11};
        range_fault = last_byte >= MEM_LIMIT;
        fault       = range_fault || !f3_ok || misalign;
    end

    lsu_load_extend u_extend (
        .word     (mem_rdata),
        .byte_off (addr_q[1:0]),
        .funct3   (funct3_q),
        .data     (ext_data)
    );

    always_comb begin
        state_d     = state_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        sdata_d     = sdata_q;
        rdata_d     = rdata_q;
        load_data_d = load_data_q;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    funct3_d = funct3;
                    addr_d   = eff_addr;
                    sdata_d  = store_data;
                    err_d    = fault;
                    if (fault) begin
                        state_d = ST_DONE;
                    end else if (!is_store) begin
                        state_d = ST_LOAD;
                    end else if (funct3 == F3_SW) begin
                        // Full-word store needs no read-modify-write.
                        state_d = ST_STORE_WR;
                    end else begin
                        state_d = ST_STORE_RD;
                    end
                end
            end
            ST_LOAD: begin
                load_data_d = ext_data;
                state_d     = ST_DONE;
            end
            ST_STORE_RD: begin
                rdata_d = mem_rdata;
                state_d = ST_STORE_WR;
            end
            ST_STORE_WR: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            funct3_q    <= 3'd0;
            addr_q      <= 32'd0;
            sdata_q     <= 32'd0;
            rdata_q     <= 32'd0;
            load_data_q <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            sdata_q     <= sdata_d;
            rdata_q     <= rdata_d;
            load_data_q <= load_data_d;
            err_q       <= err_d;
        end
    end

    // Moore outputs decoded from state only; address/data are zero when idle.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        mem_load  = (state_q == ST_LOAD) || (state_q == ST_STORE_RD);
        mem_store = (state_q == ST_STORE_WR);
        mem_en    = mem_load || mem_store;
        mem_addr  = mem_en ? {addr_q[31:2], 2'b00} : 32'd0;
        mem_wdata = mem_store ? merge_store(rdata_q, sdata_q, funct3_q, addr_q[1:0]) : 32'd0;
        err       = err_q;
        load_data = load_data_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_store;
    logic        mem_load;
    logic        mem_en;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:7];
    int          store_count = 0;
    int          done_count  = 0;

    int          checks   = 0;
    int          failures = 0;

    int          lat;
    logic        saw_en;
    logic        err_seen;
    logic [31:0] wd_seen;
    int          stores_before;

    always #5 clk = ~clk;

    load_store_unit #(.DMEM_BYTES(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .load_data  (load_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_store  (mem_store),
        .mem_load   (mem_load),
        .mem_en     (mem_en),
        .mem_rdata  (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[4:2]];

    always @(posedge clk) begin
        if (mem_en && mem_store) begin
            mem[mem_addr[4:2]] <= mem_wdata;
            store_count = store_count + 1;
        end
        if (done) done_count = done_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it until done (bounded); leaves the DUT back in IDLE.
    task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd);
        @(negedge clk);
        start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1; saw_en = 1'b0; wd_seen = 32'd0;
        while (!done && lat < 8) begin
            if (mem_en) saw_en = 1'b1;
            if (mem_store) wd_seen = mem_wdata;
            @(posedge clk); #1;
            lat++;
        end
        err_seen = err;
        @(posedge clk); #1;
    endtask

    initial begin
        mem[0] = 32'h9876_5432; mem[1] = 32'h8081_82F3;
        mem[2] = 32'h1122_3344; mem[3] = 32'h0102_0304;
        mem[4] = 32'h0000_0000; mem[5] = 32'h0000_0000;
        mem[6] = 32'h0000_0000; mem[7] = 32'hCAFE_F00D;
        start = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0; store_data = 32'd0;

        // Reset values appear without any clock edge.
        reset = 1'b1;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_mem_en", {29'd0, mem_en, mem_load, mem_store}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;

        // LB 0x05: byte 0x82 sign-extended
        access(1'b0, 3'b000, 32'h05, 32'd0);
        check("lb_data", load_data, 32'hFFFF_FF82);
        check("lb_latency", lat, 2);
        check("lb_err", {31'd0, err_seen}, 32'd0);

        // LHU 0x06 and LW 0x04
        access(1'b0, 3'b101, 32'h06, 32'd0);
        check("lhu_data", load_data, 32'h0000_8081);
        access(1'b0, 3'b010, 32'h04, 32'd0);
        check("lw_data", load_data, 32'h8081_82F3);

        // SB 0x0A 0xAB into 0x11223344
        access(1'b1, 3'b000, 32'h0A, 32'h0000_00AB);
        check("sb_wdata", wd_seen, 32'h11AB_3344);
        check("sb_latency", lat, 3);
        check("sb_err", {31'd0, err_seen}, 32'd0);
        check("sb_mem", mem[2], 32'h11AB_3344);
        check("sb_keeps_load_data", load_data, 32'h8081_82F3);

        // SW 0x10: direct write, 2 cycles
        access(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        check("sw_wdata", wd_seen, 32'hDEAD_BEEF);
        check("sw_latency", lat, 2);

        // SH 0x0C into 0x01020304
        access(1'b1, 3'b001, 32'h0C, 32'h5555_AAAA);
        check("sh_mem", mem[3], 32'h0102_AAAA);

        // Range boundary: last word ok, next word faults
        access(1'b0, 3'b010, 32'h1C, 32'd0);
        check("lw1c_data", load_data, 32'hCAFE_F00D);
        check("lw1c_err", {31'd0, err_seen}, 32'd0);
        access(1'b0, 3'b010, 32'h20, 32'd0);
        check("lw20_err", {31'd0, err_seen}, 32'd1);
        check("lw20_latency", lat, 1);
        check("lw20_no_mem_en", {31'd0, saw_en}, 32'd0);
        check("lw20_keeps_load_data", load_data, 32'hCAFE_F00D);

        // Unsupported funct3 on a load
        access(1'b0, 3'b011, 32'h04, 32'd0);
        check("badf3_err", {31'd0, err_seen}, 32'd1);
        check("badf3_latency", lat, 1);

        // Misaligned LH 0x03
        access(1'b0, 3'b001, 32'h03, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lh03_err", {31'd0, err_seen}, 32'd1);
        check("lh03_keeps_load_data", load_data, 32'hCAFE_F00D);
`else
        check("lh03_err", {31'd0, err_seen}, 32'd0);
        check("lh03_data", load_data, 32'hFFFF_9876);
`endif

        // Reset during STORE_RD aborts the store
        @(negedge clk);
        start = 1'b1; is_store = 1'b1; funct3 = 3'b000; addr = 32'h08; store_data = 32'h77;
        @(posedge clk); #1;
        start = 1'b0;
        check("abort_in_store_rd", {30'd0, mem_load, busy}, 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("abort_mem_en", {31'd0, mem_en}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        stores_before = store_count;
        done_count = 0;
        @(negedge clk); reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_store", store_count, stores_before);
        check("abort_no_done", done_count, 0);
        check("abort_mem_intact", mem[2], 32'h11AB_3344);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
